// File: rtl/ctrl_pipe_if.sv
// Control-pipe bus: D-stage opcode/hazard controls in, decoded D/E/M/W control out.
interface ctrl_pipe_if #(
    parameter int unsigned OP_W = 6
);
    logic [OP_W-1:0] op_d;
    logic            valid_d;
    logic            stall_e;
    logic            flush_e;
    logic            flush_m;

    logic branch_d;
    logic bne_d;
    logic jump_d;
    logic ri_d;

    logic regwrite_e;
    logic regdst_e;
    logic alusrc_e;
    logic memtoreg_e;
    logic link_e;
    logic valid_e;

    logic regwrite_m;
    logic memwrite_m;
    logic memtoreg_m;
    logic link_m;
    logic valid_m;

    logic regwrite_w;
    logic memtoreg_w;
    logic link_w;
    logic valid_w;

    modport master (
        output op_d, valid_d, stall_e, flush_e, flush_m,
        input  branch_d, bne_d, jump_d, ri_d,
        input  regwrite_e, regdst_e, alusrc_e, memtoreg_e, link_e, valid_e,
        input  regwrite_m, memwrite_m, memtoreg_m, link_m, valid_m,
        input  regwrite_w, memtoreg_w, link_w, valid_w
    );

    modport slave (
        input  op_d, valid_d, stall_e, flush_e, flush_m,
        output branch_d, bne_d, jump_d, ri_d,
        output regwrite_e, regdst_e, alusrc_e, memtoreg_e, link_e, valid_e,
        output regwrite_m, memwrite_m, memtoreg_m, link_m, valid_m,
        output regwrite_w, memtoreg_w, link_w, valid_w
    );
endinterface

// File: rtl/ctrl_pipe.sv
// Main decoder for the D stage plus E/M/W control pipeline registers with
// hazard-unit stall/flush handling and optional extended ISA decode.
module ctrl_pipe #(
    parameter bit          EXT_ISA = 1'b1,
    parameter int unsigned OP_W    = 6
) (
    input logic         clk,
    input logic         rst,
    ctrl_pipe_if.slave  bus
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_JAL   = 6'b000011,
        OP_BEQ   = 6'b000100,
        OP_BNE   = 6'b000101,
        OP_ADDI  = 6'b001000,
        OP_SLTI  = 6'b001010,
        OP_ANDI  = 6'b001100,
        OP_ORI   = 6'b001101,
        OP_XORI  = 6'b001110,
        OP_LUI   = 6'b001111,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_t;

    typedef struct packed {
        logic regwrite;
        logic regdst;
        logic alusrc;
        logic branch;
        logic bne;
        logic memwrite;
        logic memtoreg;
        logic jump;
        logic link;
    } dec_t;

    typedef struct packed {
        logic regwrite;
        logic regdst;
        logic alusrc;
        logic memwrite;
        logic memtoreg;
        logic link;
        logic valid;
    } e_t;

    typedef struct packed {
        logic regwrite;
        logic memwrite;
        logic memtoreg;
        logic link;
        logic valid;
    } m_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic link;
        logic valid;
    } w_t;

    dec_t dec;
    logic ri;
    e_t   e_q, e_d;
    m_t   m_q, m_d;
    w_t   w_q, w_d;

    // Raw opcode decode; invalid D slots and reserved opcodes both yield an all-zero word.
    always_comb begin
        dec = '0;
        ri  = 1'b0;
        case (op_d_6())
            OP_RTYPE: begin
                dec.regwrite = 1'b1;
                dec.regdst   = 1'b1;
            end
            OP_LW: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.memtoreg = 1'b1;
            end
            OP_SW: begin
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
            end
            OP_BEQ: dec.branch = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
            end
            OP_J: dec.jump = 1'b1;
            OP_BNE: begin
                if (EXT_ISA) begin
                    dec.branch = 1'b1;
                    dec.bne    = 1'b1;
                end else begin
                    ri = 1'b1;
                end
            end
            OP_JAL: begin
                if (EXT_ISA) begin
                    dec.jump     = 1'b1;
                    dec.regwrite = 1'b1;
                    dec.link     = 1'b1;
                end else begin
                    ri = 1'b1;
                end
            end
            OP_SLTI: begin
                if (EXT_ISA) begin
                    dec.regwrite = 1'b1;
                    dec.alusrc   = 1'b1;
                end else begin
                    ri = 1'b1;
                end
            end
            default: ri = 1'b1;
        endcase
        if (!bus.valid_d || ri) begin
            dec = '0;
        end
        if (!bus.valid_d) begin
            ri = 1'b0;
        end
    end

    function automatic logic [5:0] op_d_6();
        return 6'(bus.op_d);
    endfunction

    assign bus.branch_d = dec.branch;
    assign bus.bne_d    = dec.bne;
    assign bus.jump_d   = dec.jump;
    assign bus.ri_d     = ri;

    always_comb begin
        e_d = e_q;
        if (bus.flush_e) begin
            e_d = '0;
        end else if (!bus.stall_e) begin
            e_d.regwrite = dec.regwrite;
            e_d.regdst   = dec.regdst;
            e_d.alusrc   = dec.alusrc;
            e_d.memwrite = dec.memwrite;
            e_d.memtoreg = dec.memtoreg;
            e_d.link     = dec.link;
            e_d.valid    = bus.valid_d & ~ri;
        end
    end

    // A stall holds E, so M must take a bubble or the held instruction would issue twice.
    always_comb begin
        m_d = '0;
        if (!bus.flush_m && !bus.stall_e) begin
            m_d.regwrite = e_q.regwrite;
            m_d.memwrite = e_q.memwrite;
            m_d.memtoreg = e_q.memtoreg;
            m_d.link     = e_q.link;
            m_d.valid    = e_q.valid;
        end
    end

    always_comb begin
        w_d          = '0;
        w_d.regwrite = m_q.regwrite;
        w_d.memtoreg = m_q.memtoreg;
        w_d.link     = m_q.link;
        w_d.valid    = m_q.valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    assign bus.regwrite_e = e_q.regwrite;
    assign bus.regdst_e   = e_q.regdst;
    assign bus.alusrc_e   = e_q.alusrc;
    assign bus.memtoreg_e = e_q.memtoreg;
    assign bus.link_e     = e_q.link;
    assign bus.valid_e    = e_q.valid;

    assign bus.regwrite_m = m_q.regwrite;
    assign bus.memwrite_m = m_q.memwrite;
    assign bus.memtoreg_m = m_q.memtoreg;
    assign bus.link_m     = m_q.link;
    assign bus.valid_m    = m_q.valid;

    assign bus.regwrite_w = w_q.regwrite;
    assign bus.memtoreg_w = w_q.memtoreg;
    assign bus.link_w     = w_q.link;
    assign bus.valid_w    = w_q.valid;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Drives identical stimulus into an EXT_ISA=1 and an EXT_ISA=0 instance and
// scores every stage against an independent decode/pipeline model.
module tb_ctrl_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   mw_cnt   = 0;

    always #5 clk = ~clk;

    ctrl_pipe_if #(.OP_W(6)) bus1 ();
    ctrl_pipe_if #(.OP_W(6)) bus0 ();

    ctrl_pipe #(.EXT_ISA(1'b1), .OP_W(6)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    ctrl_pipe #(.EXT_ISA(1'b0), .OP_W(6)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

    // Model stage state, index = EXT_ISA. E: {rw,rd,as,mw,mt,lk,v}, M: {rw,mw,mt,lk,v}, W: {rw,mt,lk,v}.
    logic [6:0] me [2] = '{7'd0, 7'd0};
    logic [4:0] mm [2] = '{5'd0, 5'd0};
    logic [3:0] mw [2] = '{4'd0, 4'd0};
    logic [14:0] sb1 [$];
    logic [14:0] sb0 [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {ri, rw,rd,as,br,bne,mw,mt,j,lk}.
    function automatic logic [9:0] model_dec(input logic [5:0] op, input logic vd, input bit ext);
        logic [8:0] w;
        logic       r;
        w = '0;
        r = 1'b0;
        case (op)
            6'b000000: w = 9'b110000000;
            6'b100011: w = 9'b101000100;
            6'b101011: w = 9'b001001000;
            6'b000100: w = 9'b000100000;
            6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001111: w = 9'b101000000;
            6'b000010: w = 9'b000000010;
            6'b000101: if (ext) w = 9'b000110000; else r = 1'b1;
            6'b000011: if (ext) w = 9'b100000011; else r = 1'b1;
            6'b001010: if (ext) w = 9'b101000000; else r = 1'b1;
            default:   r = 1'b1;
        endcase
        if (r || !vd) w = '0;
        if (!vd) r = 1'b0;
        return {r, w};
    endfunction

    function automatic logic [3:0] obs_comb(input bit ext);
        if (ext) return {bus1.branch_d, bus1.bne_d, bus1.jump_d, bus1.ri_d};
        return {bus0.branch_d, bus0.bne_d, bus0.jump_d, bus0.ri_d};
    endfunction

    function automatic logic [14:0] obs_stage(input bit ext);
        if (ext)
            return {bus1.regwrite_e, bus1.regdst_e, bus1.alusrc_e, bus1.memtoreg_e, bus1.link_e, bus1.valid_e,
                    bus1.regwrite_m, bus1.memwrite_m, bus1.memtoreg_m, bus1.link_m, bus1.valid_m,
                    bus1.regwrite_w, bus1.memtoreg_w, bus1.link_w, bus1.valid_w};
        return {bus0.regwrite_e, bus0.regdst_e, bus0.alusrc_e, bus0.memtoreg_e, bus0.link_e, bus0.valid_e,
                bus0.regwrite_m, bus0.memwrite_m, bus0.memtoreg_m, bus0.link_m, bus0.valid_m,
                bus0.regwrite_w, bus0.memtoreg_w, bus0.link_w, bus0.valid_w};
    endfunction

    task automatic step(input logic r, input logic [5:0] op, input logic vd,
                        input logic st, input logic fe, input logic fm);
        logic [9:0]  d;
        logic [6:0]  ne;
        logic [4:0]  nm;
        logic [3:0]  nw;
        logic [14:0] exp;
        rst = r;
        bus1.op_d = op; bus1.valid_d = vd; bus1.stall_e = st; bus1.flush_e = fe; bus1.flush_m = fm;
        bus0.op_d = op; bus0.valid_d = vd; bus0.stall_e = st; bus0.flush_e = fe; bus0.flush_m = fm;
        #1;
        for (int x = 0; x < 2; x++) begin
            d = model_dec(op, vd, x[0]);
            check($sformatf("comb ext%0d op%b", x, op), 32'(obs_comb(x[0])), 32'({d[5], d[4], d[1], d[9]}));
            if (r) begin
                ne = '0; nm = '0; nw = '0;
            end else begin
                nw = {mm[x][4], mm[x][2], mm[x][1], mm[x][0]};
                nm = (fm || st) ? 5'd0 : {me[x][6], me[x][3], me[x][2], me[x][1], me[x][0]};
                if (fe)      ne = '0;
                else if (st) ne = me[x];
                else         ne = {d[8], d[7], d[6], d[3], d[2], d[0], vd & ~d[9]};
            end
            me[x] = ne; mm[x] = nm; mw[x] = nw;
            exp = {ne[6], ne[5], ne[4], ne[2], ne[1], ne[0], nm, nw};
            if (x == 1) sb1.push_back(exp); else sb0.push_back(exp);
        end
        @(posedge clk);
        #1;
        check("sb1 depth", 32'(sb1.size()), 32'd1);
        check("sb0 depth", 32'(sb0.size()), 32'd1);
        if (sb1.size() > 0) check($sformatf("stages ext1 op%b", op), 32'(obs_stage(1'b1)), 32'(sb1.pop_front()));
        if (sb0.size() > 0) check($sformatf("stages ext0 op%b", op), 32'(obs_stage(1'b0)), 32'(sb0.pop_front()));
        mw_cnt += int'(bus1.memwrite_m);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [5:0] ops [16] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b001100,
                             6'b001101, 6'b001110, 6'b001111, 6'b000010, 6'b000101, 6'b000011,
                             6'b001010, 6'b111111, 6'b010001, 6'b100000};

    initial begin
        // Reset: comb outputs still follow op_d.
        step(1'b1, 6'b100011, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 6'b000101, 1'b1, 1'b0, 1'b0, 1'b0);
        check("E/M/W zero after reset", 32'(obs_stage(1'b1)), 32'd0);

        // LW through the pipe.
        step(1'b0, 6'b100011, 1'b1, 1'b0, 1'b0, 1'b0);
        check("LW in E", 32'({bus1.regwrite_e, bus1.alusrc_e, bus1.memtoreg_e, bus1.regdst_e, bus1.valid_e}), 32'b11101);
        nop(1);
        check("LW in M", 32'({bus1.memtoreg_m, bus1.memwrite_m, bus1.valid_m}), 32'b101);
        nop(1);
        check("LW in W", 32'({bus1.regwrite_w, bus1.memtoreg_w, bus1.valid_w}), 32'b111);
        nop(1);

        // SW then flushed R_TYPE.
        mw_cnt = 0;
        step(1'b0, 6'b101011, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 6'b000000, 1'b1, 1'b0, 1'b1, 1'b0);
        nop(4);
        check("memwrite_m pulses", 32'(mw_cnt), 32'd1);

        // LW stalled in E for two cycles.
        step(1'b0, 6'b100011, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 6'b001000, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 6'b001000, 1'b1, 1'b1, 1'b0, 1'b0);
        check("M bubble while stalled", 32'(bus1.valid_m), 32'd0);
        step(1'b0, 6'b001000, 1'b1, 1'b0, 1'b0, 1'b0);
        check("LW reaches M once", 32'({bus1.memtoreg_m, bus1.valid_m}), 32'b11);
        nop(1);
        check("ADDI follows LW", 32'({bus1.memtoreg_m, bus1.regwrite_m}), 32'b01);
        nop(2);

        // Every opcode, including EXT and reserved ones.
        for (int i = 0; i < 16; i++) step(1'b0, ops[i], 1'b1, 1'b0, 1'b0, 1'b0);
        nop(3);

        // JAL link carried to W.
        step(1'b0, 6'b000011, 1'b1, 1'b0, 1'b0, 1'b0);
        nop(2);
        check("JAL link_w", 32'({bus1.link_w, bus1.regwrite_w, bus0.valid_w}), 32'b110);

        // ADDI-filled pipe then a one-cycle reset.
        for (int i = 0; i < 3; i++) step(1'b0, 6'b001000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 6'b001000, 1'b1, 1'b0, 1'b0, 1'b0);
        check("mid-stream reset", 32'(obs_stage(1'b1)), 32'd0);
        step(1'b0, 6'b100011, 1'b0, 1'b0, 1'b0, 1'b0);
        nop(3);

        // Flush/stall interactions.
        step(1'b0, 6'b100011, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 6'b101011, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 6'b001101, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b1);
        nop(3);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 15)],
                 ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Parametrised successor to the single-cycle main decoder: decodes the D-stage opcode into a control word and carries it through pipeline registers to E, M and W.
- Adds optional extended ISA decode (BNE, JAL, SLTI), reserved-instruction detection, per-stage valid bits, and hazard-unit stall/flush control.
- Sits between the instruction register (D stage) and the datapath muxes; the hazard unit drives stall/flush.

Parameters:
- EXT_ISA, 1: 1 decodes BNE/JAL/SLTI; 0 treats them as reserved.
- OP_W, 6: opcode width (fixed 6 for MIPS; exposed for lint only).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op_d  in  OP_W  opcode of instruction in D.
- valid_d  in  1  D holds a real instruction.
- stall_e  in  1  hold E register; inject bubble into M.
- flush_e  in  1  load bubble into E.
- flush_m  in  1  load bubble into M.
- branch_d  out  1  BEQ or BNE in D (comb).
- bne_d  out  1  branch-on-not-equal (comb).
- jump_d  out  1  J or JAL in D (comb).
- ri_d  out  1  reserved/unsupported opcode with valid_d=1 (comb).
- regwrite_e, regdst_e, alusrc_e, memtoreg_e, link_e, valid_e  out  1 each  E-stage control.
- regwrite_m, memwrite_m, memtoreg_m, link_m, valid_m  out  1 each  M-stage control.
- regwrite_w, memtoreg_w, link_w, valid_w  out  1 each  W-stage control.

Behaviour:
- Decode is combinational on op_d. Fields: {regwrite, regdst, alusrc, branch, bne, memwrite, memtoreg, jump, link}.
  - R_TYPE 000000: regwrite, regdst.
  - LW 100011: regwrite, alusrc, memtoreg.
  - SW 101011: alusrc, memwrite.
  - BEQ 000100: branch.
  - ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, LUI 001111: regwrite, alusrc.
  - J 000010: jump.
  - EXT_ISA=1 only:
    - BNE 000101: branch, bne.
    - JAL 000011: jump, regwrite, link (datapath selects r31 / PC+8 on link).
    - SLTI 001010: regwrite, alusrc.
- Any other opcode, or an EXT opcode with EXT_ISA=0: all fields 0, ri_d=1.
- valid_d=0 forces the decoded word to all-0 and ri_d=0.
- Bubble: all control bits 0, including valid.
- E register, each rising edge. Priority: rst > flush_e > stall_e > load.
  - rst or flush_e: bubble.
  - stall_e: hold.
  - Otherwise: load the decoded D word; valid_e = valid_d & ~ri_d.
  - ri_d instructions enter E as a bubble (exception logic is out of scope).
- M register. Priority: rst > flush_m > stall_e > load.
  - rst, flush_m or stall_e: bubble. A stall never duplicates an instruction into M.
  - Otherwise: load from E.
- W register: rst gives bubble; otherwise always loads from M. No stall or flush.
- Latency: decode to E = 1 cycle, to M = 2, to W = 3.
- flush_e and stall_e together: flush wins; E becomes a bubble and M also takes a bubble.
- All registered outputs are 0 while rst=1 and on the first cycle after it. Comb D outputs follow op_d/valid_d during reset.
- Reset asserted mid-stream clears E, M and W on the same edge; in-flight instructions are discarded.
- No other state. Implementation is one decode block plus three stage registers (~150-250 lines).

Test Plan:
- Reset then LW (100011), valid_d=1, no stall: E at +1 has regwrite=1, alusrc=1, memtoreg=1, regdst=0; M at +2 has memtoreg=1, memwrite=0; W at +3 has regwrite=1, memtoreg=1, valid_w=1.
- SW then R_TYPE back-to-back, flush_e=1 in the R_TYPE cycle: E/M/W sequence shows the SW word followed by an all-zero bubble (valid=0); memwrite_m=1 for exactly one cycle.
- LW in E, stall_e=1 for 2 cycles: E outputs stay constant for both cycles; M carries valid_m=0 for 2 cycles; the LW reaches M on the cycle after stall_e drops, exactly once.
- EXT_ISA=0, op_d=000101 (BNE): ri_d=1, branch_d=0, and E gets a bubble. With EXT_ISA=1: ri_d=0, branch_d=1, bne_d=1.
- EXT_ISA=1, JAL (000011): jump_d=1; E shows regwrite_e=1, link_e=1; link_w=1 at +3. op 111111 gives ri_d=1.
- Pipeline full of ADDI, rst=1 for 1 cycle: all E/M/W outputs 0 on the next edge; valid_d=0 with op_d=100011 gives all outputs 0.
